dmem_arbiter: RTL

Shares the single-port synchronous data memory between the CPU MEM stage and the camera pixel writer. The CPU has fixed priority. A starvation counter guarantees the camera a grant after a bounded wait. The block stalls the pipeline (IF/ID/EX/MEM freeze) while a CPU access waits for the port or for read data. It sits between the MEM stage, where the write-data path feeds it, and the data RAM.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_sat_counter.sv | 28 ++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter
// between the CPU MEM stage and the camera pixel writer.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_CAM
    } arb_gnt_t;

    localparam int DMEM_MEM_LAT    = 1;
    localparam int DMEM_STARVE_MAX = 8;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
// Clear has priority over increment.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, camera gets a forced
// slot after STARVE_MAX refusals. Optional perf counters under DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DMEM_MEM_LAT,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_cam_cnt
`endif
);

    localparam logic [2:0] LP_MEM_LAT    = 3'(MEM_LAT);
    localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_gnt_t          w_gnt;
    logic [2:0]        r_lat_cnt;
    logic [2:0]        w_lat_next;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        w_starve_cnt;
    logic              w_cam_force;
    logic              w_data_cycle;
    logic              w_cam_xfer;

    assign w_cam_force = cam_valid && (w_starve_cnt == LP_STARVE_MAX);

    // Grant decision and next state; everything is held off while reset is low.
    always_comb begin
        w_gnt        = GNT_NONE;
        w_next_state = r_state;
        w_lat_next   = r_lat_cnt;
        w_data_cycle = 1'b0;
        cpu_stall    = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (w_cam_force || (cam_valid && !cpu_req)) begin
                        w_gnt     = GNT_CAM;
                        cpu_stall = cpu_req;
                    end else if (cpu_req) begin
                        w_gnt = GNT_CPU;
                        if (!cpu_we) begin
                            cpu_stall    = 1'b1;
                            w_lat_next   = LP_MEM_LAT;
                            w_next_state = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    w_lat_next = r_lat_cnt - 3'd1;
                    if (r_lat_cnt > 3'd1) begin
                        cpu_stall = 1'b1;
                    end else begin
                        // Data cycle: cpu_req belongs to the retiring load, so only the camera may go.
                        w_data_cycle = 1'b1;
                        w_next_state = IDLE;
                        if (cam_valid) begin
                            w_gnt = GNT_CAM;
                        end
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Memory port steering from the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cam_ready = 1'b0;
        case (w_gnt)
            GNT_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_we ? cpu_wdata : '0;
            end
            GNT_CAM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cam_addr;
                mem_wdata = cam_data;
                cam_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cam_xfer = cam_valid && cam_ready;
    assign cpu_rdata  = w_data_cycle ? mem_rdata : r_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_lat_next;
            if (w_data_cycle) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    sat_counter #(
        .WIDTH (8),
        .MAX   (LP_STARVE_MAX)
    ) u_starve_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_cam_xfer),
        .i_inc   (cam_valid && !cam_ready),
        .o_count (w_starve_cnt)
    );

`ifdef DMEM_ARB_PERF_EN
    sat_counter #(
        .WIDTH (32)
    ) u_perf_stall (
        .clock   (clock),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (cpu_stall),
        .o_count (perf_stall_cnt)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_perf_cam (
        .clock   (clock),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (w_cam_xfer),
        .o_count (perf_cam_cnt)
    );
`endif

endmodule
